// File: rtl/fifo_pkg.sv
// Shared constants for the 8-entry FIFO and its stream reader: word width, address width,
// and the staging-buffer occupancy encoding.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH  = 3;
  localparam int unsigned STATS_WIDTH = 16;

  // Occupancy of the stream staging buffer doubles as its FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/tail staging buffer: captures a word on i_capture and presents the head
// as a valid/ready stream, absorbing one extra word of back-pressure.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_capture,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  buf_state_e   r_state;
  buf_state_e   w_state_next;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_xfer;
  logic         w_load_head;
  logic         w_load_tail;
  logic         w_shift;

  assign w_xfer = (r_state != EMPTY) && i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next occupancy plus which register loads; a capture at TWO cannot occur (caller gates it).
  always_comb begin
    w_state_next = r_state;
    w_load_head  = 1'b0;
    w_load_tail  = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (i_capture) begin
          w_state_next = ONE;
          w_load_head  = 1'b1;
        end
      end
      ONE: begin
        if (i_capture && w_xfer) begin
          w_load_head = 1'b1;
        end else if (i_capture) begin
          w_state_next = TWO;
          w_load_tail  = 1'b1;
        end else if (w_xfer) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        if (w_xfer) begin
          w_state_next = ONE;
          w_shift      = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_load_head) begin
        r_head <= i_data;
      end else if (w_shift) begin
        r_head <= r_tail;
      end
      if (w_load_tail) begin
        r_tail <= i_data;
      end
    end
  end

  assign o_valid = (r_state != EMPTY);
  assign o_data  = r_head;
  assign o_count = r_state;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO read port into a valid/ready stream through a two-entry staging buffer.
// Optional transfer counter port xfer_count is built when STREAM_READER_STATS_EN is defined.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef STREAM_READER_STATS_EN
  ,
  output logic [fifo_pkg::STATS_WIDTH-1:0] xfer_count
`endif
);

  import fifo_pkg::*;

  logic [1:0] w_count;

  // Pop only from registered occupancy and the FIFO flag; m_ready never reaches rd.
  assign rd = !reset && !empty && (w_count != 2'(TWO));

  stream_skid_buf #(
    .W(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_capture (rd),
    .i_data    (r_data),
    .o_valid   (m_valid),
    .i_ready   (m_ready),
    .o_data    (m_data),
    .o_count   (w_count)
  );

`ifdef STREAM_READER_STATS_EN
  logic [STATS_WIDTH-1:0] r_xfer_count;
  logic                   w_xfer;

  assign w_xfer = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (w_xfer) begin
      r_xfer_count <= r_xfer_count + STATS_WIDTH'(1);
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO modelled as a queue, staged words as a queue,
// directed phases from a table plus reset and random sequences.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef STREAM_READER_STATS_EN
  logic [15:0] xfer_count;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .clk     (clk),
    .reset   (reset),
    .empty   (empty),
    .r_data  (r_data),
    .rd      (rd),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef STREAM_READER_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  typedef struct {
    int         n_push;
    logic [7:0] base;
    int         cycles;
    int         rdy_mode;   // 0 low, 1 high, 2 alternate starting high, 3 random
    int         exp_rd;
    int         exp_xfer;
    logic       exp_valid;
  } vec_t;

  vec_t       vt[5];
  logic [7:0] fq[$];      // words sitting in the FIFO
  logic [7:0] st_q[$];    // words staged in the reader, head first
  logic [7:0] hold = 8'h00;
  logic [15:0] xcnt = 16'h0000;
  int         n_checks = 0;
  int         n_errors = 0;
  int         ph_rd;
  int         ph_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance model and FIFO.
  task automatic step(input logic rst_i, input logic rdy_i);
    logic       e_rd;
    logic       e_val;
    logic       e_x;
    logic       s_rd;
    logic [7:0] e_dat;
    logic [7:0] cap;
    @(negedge clk);
    reset   = rst_i;
    m_ready = rdy_i;
    empty   = (fq.size() == 0);
    r_data  = empty ? 8'h00 : fq[0];
    #1;
    e_rd  = !rst_i && (fq.size() != 0) && (st_q.size() < 2);
    e_val = (st_q.size() != 0);
    e_dat = e_val ? st_q[0] : hold;
    e_x   = e_val && rdy_i;
    chk("rd", 32'(rd), 32'(e_rd));
    chk("m_valid", 32'(m_valid), 32'(e_val));
    chk("m_data", 32'(m_data), 32'(e_dat));
    chk("count", 32'(dut.w_count), 32'(st_q.size()));
`ifdef STREAM_READER_STATS_EN
    chk("xfer_count", 32'(xfer_count), 32'(xcnt));
`endif
    s_rd  = rd;
    ph_rd += int'(rd);
    ph_x  += int'(m_valid && m_ready);
    cap   = r_data;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() != 0) void'(fq.pop_front());
    if (rst_i) begin
      st_q.delete();
      fq.delete();
      hold = 8'h00;
      xcnt = 16'h0000;
    end else begin
      if (e_x) begin
        hold = st_q.pop_front();
        xcnt = xcnt + 16'd1;
      end
      if (e_rd) st_q.push_back(cap);
      if (st_q.size() != 0) hold = st_q[0];
    end
  endtask

  initial begin
    logic r;
    vt[0] = '{8, 8'h11, 10, 1, 8, 8, 1'b0};   // continuous drain
    vt[1] = '{4, 8'h11,  6, 0, 2, 0, 1'b1};   // back-pressure
    vt[2] = '{0, 8'h00,  6, 1, 2, 4, 1'b0};   // release back-pressure
    vt[3] = '{0, 8'h00, 20, 3, 0, 0, 1'b0};   // FIFO empty
    vt[4] = '{8, 8'hA0, 20, 2, 8, 8, 1'b0};   // toggling ready

    repeat (2) @(posedge clk);
    step(1'b1, 1'b0);

    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < vt[p].n_push; i++) fq.push_back(8'(int'(vt[p].base) + 17 * i));
      ph_rd = 0;
      ph_x  = 0;
      for (int c = 0; c < vt[p].cycles; c++) begin
        case (vt[p].rdy_mode)
          0:       r = 1'b0;
          1:       r = 1'b1;
          2:       r = ((c % 2) == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        step(1'b0, r);
      end
      chk($sformatf("ph%0d_rd_pulses", p), 32'(ph_rd), 32'(vt[p].exp_rd));
      chk($sformatf("ph%0d_xfers", p), 32'(ph_x), 32'(vt[p].exp_xfer));
      chk($sformatf("ph%0d_valid_end", p), 32'(m_valid), 32'(vt[p].exp_valid));
    end

    // Reset with two words staged and more waiting in the FIFO.
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h31 + i));
    repeat (3) step(1'b0, 1'b0);
    chk("pre_rst_count", 32'(dut.w_count), 32'd2);
    step(1'b1, 1'b1);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_data", 32'(m_data), 32'd0);
    step(1'b0, 1'b1);
    chk("post_rst_rd", 32'(rd), 32'd0);

`ifdef STREAM_READER_STATS_EN
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h11 * (i + 1)));
    repeat (10) step(1'b0, 1'b1);
    chk("stats_eight", 32'(xfer_count), 32'd8);
    @(negedge clk);
    force dut.r_xfer_count = 16'hFFFF;
    #1;
    release dut.r_xfer_count;
    xcnt = 16'hFFFF;
    fq.push_back(8'h5A);
    repeat (4) step(1'b0, 1'b1);
    chk("stats_wrap", 32'(xfer_count), 32'h0000);
`endif

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) fq.push_back(8'($urandom));
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1);
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter that drains the 8-entry FIFO (fifo_controller plus register file) and presents its contents as a valid/ready stream to a downstream consumer. It issues `rd` pops to the controller and captures the register-file read data at the same edge. A two-entry output buffer sustains one word per cycle under continuous `m_ready` and absorbs back-pressure without losing data. It sits between the FIFO read port and any stream consumer, such as a UART TX or DMA sink.

## Interface
- DATA_WIDTH, 8, width of FIFO words and stream data
- clk  in  1  rising-edge clock shared with fifo_controller
- reset  in  1  synchronous, active-high; clears all state
- empty  in  1  fifo_controller empty flag
- r_data  in  DATA_WIDTH  register-file data at current r_addr (combinational read)
- rd  out  1  pop strobe to fifo_controller
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  stream data (head of buffer)
- xfer_count  out  16  completed transfers (only with STREAM_READER_STATS_EN)

## Operation
- Internal `count` (0..2) tracks staged words; head and tail registers.
- `rd = !reset && !empty && count < 2`. The rule is combinational from registered `count` and `empty` only, with no path from `m_ready` to `rd`.
- `xfer = m_valid && m_ready`.
- `count_next = count + rd - xfer`.
- Capture on `rd`:
  - into head when `count==0`, or when `count==1 && xfer`;
  - into tail when `count==1 && !xfer`.
  - `count==2` never captures, because `rd` is 0.
- On `xfer` at `count==2`: head <= tail.
- `m_valid = (count != 0)`; `m_data` = head.
- Order is strictly FIFO; no word is duplicated or dropped.
- Stream rules:
  - Once asserted, `m_valid` holds until accepted.
  - `m_data` is stable while `m_valid && !m_ready`.
- States:
  - EMPTY (count 0) goes to ONE on `rd`.
  - ONE goes to TWO on `rd && !xfer`, to EMPTY on `!rd && xfer`, and otherwise stays.
  - TWO goes to ONE on `xfer`, and otherwise stays.

## Timing
- Reset values: `count`=0, `m_valid`=0, `m_data`=0, `rd`=0, `xfer_count`=0.
- Latency: `empty` falls in cycle N, so `rd` is high in cycle N and `m_valid` is high with the word in cycle N+1.
- Throughput is 1 word/cycle with `m_ready` held high: `count` stays 1 and `rd` pulses every cycle.
- Back-pressure: with `m_ready`=0, at most 2 pops occur, then `rd` stays low until a transfer frees an entry. `rd` resumes the cycle after `count` drops below 2.
- FIFO empty: `rd` stays 0, and staged words still drain.
- Simultaneous pop and transfer at `count==1` is legal; `count` holds.
- Reset mid-operation discards staged words. The next cycle has `m_valid`=0 regardless of `m_ready`. fifo_controller is reset on the same signal.
- `xfer_count` wraps from 0xFFFF to 0x0000.

## Configuration
- STREAM_READER_STATS_EN
  - Defined: the `xfer_count` port exists and increments by 1 on every `xfer`, synchronously cleared by `reset`.
  - Undefined: the port and counter are absent, and the datapath is otherwise identical.

## Structure
- Shared package `fifo_pkg` holds:
  - DATA_WIDTH default (8);
  - FIFO ADDR_WIDTH (3);
  - the state/count encoding constants: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- One sub-module, `stream_skid_buf`, is natural. It holds the head/tail registers and count, with an input capture strobe and an output valid/ready pair.
- The top level adds the `rd` rule and the optional stats counter.

## Test plan
- Continuous drain:
  - Stimulus: preload FIFO with 0x11,0x22,...,0x88 and hold `m_ready`=1.
  - Required: 8 `rd` pulses on consecutive cycles; `m_data` 0x11..0x88 on 8 consecutive cycles starting one cycle after the first `rd`; `m_valid` falls after 0x88.
- Back-pressure:
  - Stimulus: preload 4 words and hold `m_ready`=0.
  - Required: exactly 2 `rd` pulses, and `m_data`=0x11 held steady.
  - Stimulus: raise `m_ready`.
  - Required: 0x11, 0x22, 0x33, 0x44 in order with no gaps after the first.
- Empty FIFO:
  - Stimulus: `empty`=1 for 20 cycles.
  - Required: `rd`=0 and `m_valid`=0 throughout.
- Toggling `m_ready`:
  - Stimulus: 8 words with `m_ready` alternating 1/0.
  - Required: all 8 words delivered exactly once in order; `count` never exceeds 2.
- Reset mid-operation:
  - Stimulus: `count`=2, then assert `reset` for 1 cycle.
  - Required: next cycle `m_valid`=0, `rd`=0, `m_data`=0.
- Stats (STREAM_READER_STATS_EN):
  - Stimulus: 8 transfers.
  - Required: `xfer_count`=8.
  - Stimulus: force the counter to 0xFFFF, then one transfer.
  - Required: `xfer_count`=0x0000.
